// File: rtl/rmii_phy_rx_gen.sv
// rmii_phy_rx_gen
// PHY-side RMII frame generator. Drives the MAC receive pins from a byte
// buffer: preamble, SFD, payload, CRC-32 FCS, then an inter-frame gap.
// One dibit is emitted every two clk cycles; phy_clk is the internally
// generated 50 MHz reference (ph), and line outputs change only on the clk
// edge where ph rises ("step"), so they are stable for a full RMII period.
//
// Optional feature macro: RMII_PHY_ERR_INJ_EN
//   defined   -> adds err_inj / err_byte inputs (latched with tx_vld);
//                phy_rx_err is raised for the 4 dibits of payload byte
//                err_byte. Data and FCS are unaffected.
//   undefined -> no extra ports, phy_rx_err tied low.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   resetn      in   synchronous reset, active-low
//   tx_vld      in   start request pulse, latches tx_count when idle
//   tx_count    in   index of the last payload byte (length-1)
//   tx_addr     out  payload byte address presented to the buffer
//   tx_adv      out  pulse: byte at tx_addr consumed, address advanced
//   tx_busy     out  frame or IFG in progress
//   tx_data     in   payload byte for tx_addr (1 clk read latency allowed)
//   frame_done  out  pulse at the end of the IFG
//   phy_clk     out  RMII reference clock
//   phy_rxd     out  RMII receive dibit
//   phy_crs_dv  out  carrier sense / data valid
//   phy_rx_err  out  receive error
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line quiet; a latched request starts a frame on the next step
// PRMBL | 2'b01 dibits, PRMBL_DIBITS steps
// SFD   | single 2'b11 dibit
// DATA  | payload dibits, LSB dibit of each byte first
// FCS   | 16 dibits of the complemented CRC, LSB first
// IFG   | crs_dv low for IFG_DIBITS steps, then frame_done

module rmii_phy_rx_gen #(
    parameter int PRMBL_DIBITS = 31,
    parameter int IFG_DIBITS   = 48
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tx_vld,
    input  logic [10:0] tx_count,
    output logic [10:0] tx_addr,
    output logic        tx_adv,
    output logic        tx_busy,
    input  logic [7:0]  tx_data,
    output logic        frame_done,
`ifdef RMII_PHY_ERR_INJ_EN
    input  logic        err_inj,
    input  logic [10:0] err_byte,
`endif
    output logic        phy_clk,
    output logic [1:0]  phy_rxd,
    output logic        phy_crs_dv,
    output logic        phy_rx_err
);

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_PRMBL = 6'b000010;
    localparam logic [5:0] S_SFD   = 6'b000100;
    localparam logic [5:0] S_DATA  = 6'b001000;
    localparam logic [5:0] S_FCS   = 6'b010000;
    localparam logic [5:0] S_IFG   = 6'b100000;

    localparam int CNT_MAX = (PRMBL_DIBITS > IFG_DIBITS) ? PRMBL_DIBITS : IFG_DIBITS;
    localparam int CW      = $clog2((CNT_MAX > 16) ? CNT_MAX : 16) + 1;

    localparam logic [CW-1:0] PRMBL_LOAD = CW'(PRMBL_DIBITS - 1);
    localparam logic [CW-1:0] FCS_LOAD   = CW'(15);
    // The step that fires frame_done is itself the last IFG step, so the
    // counter is loaded two short of the gap length.
    localparam logic [CW-1:0] IFG_LOAD   = CW'(IFG_DIBITS - 2);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic          ph_q;
    logic          step;
    logic [5:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    di_q, di_d;
    logic          last_q, last_d;
    logic [7:0]    byte_q, byte_d;
    logic [31:0]   crc_q, crc_d;
    logic [1:0]    rxd_q, rxd_d;
    logic          crs_q, crs_d;
    logic [10:0]   addr_q, addr_d;
    logic          adv_q, adv_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [10:0]   count_q, count_d;
    logic          start_byte;
    logic [1:0]    dib;

    // ph is still low on the edge where it rises.
    assign step = ~ph_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        di_d       = di_q;
        last_d     = last_q;
        byte_d     = byte_q;
        crc_d      = crc_q;
        rxd_d      = rxd_q;
        crs_d      = crs_q;
        addr_d     = addr_q;
        adv_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        count_d    = count_q;
        start_byte = 1'b0;
        dib        = 2'b00;

        // busy doubles as the pending-start flag while in IDLE
        if (tx_vld && !busy_q) begin
            busy_d  = 1'b1;
            count_d = tx_count;
        end

        if (step) begin
            case (state_q)
                S_IDLE: begin
                    rxd_d = 2'b00;
                    crs_d = 1'b0;
                    if (busy_q) begin
                        state_d = S_PRMBL;
                        rxd_d   = 2'b01;
                        crs_d   = 1'b1;
                        cnt_d   = PRMBL_LOAD;
                        crc_d   = '1;
                        addr_d  = '0;
                        di_d    = 2'd0;
                        last_d  = 1'b0;
                    end
                end
                S_PRMBL: begin
                    if (cnt_q == '0) begin
                        state_d = S_SFD;
                        rxd_d   = 2'b11;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        rxd_d = 2'b01;
                    end
                end
                S_SFD: begin
                    state_d    = S_DATA;
                    start_byte = 1'b1;
                end
                S_DATA: begin
                    if (di_q == 2'd0) begin
                        if (last_q) begin
                            state_d = S_FCS;
                            rxd_d   = ~crc_q[1:0];
                            crc_d   = {2'b00, crc_q[31:2]};
                            cnt_d   = FCS_LOAD;
                        end else begin
                            start_byte = 1'b1;
                        end
                    end else begin
                        case (di_q)
                            2'd1:    dib = byte_q[3:2];
                            2'd2:    dib = byte_q[5:4];
                            default: dib = byte_q[7:6];
                        endcase
                        rxd_d = dib;
                        crc_d = crc2(crc_q, dib);
                        di_d  = di_q + 2'd1;
                        if (di_q == 2'd3) begin
                            adv_d = 1'b1;
                            // hold the address on the last byte so it never wraps
                            if (addr_q == count_q) last_d = 1'b1;
                            else                   addr_d = addr_q + 11'd1;
                        end
                    end
                end
                S_FCS: begin
                    if (cnt_q == '0) begin
                        state_d = S_IFG;
                        rxd_d   = 2'b00;
                        crs_d   = 1'b0;
                        cnt_d   = IFG_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        rxd_d = ~crc_q[1:0];
                        crc_d = {2'b00, crc_q[31:2]};
                    end
                end
                S_IFG: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rxd_d   = 2'b00;
                    crs_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase

            // the buffer had two clk since tx_addr moved, so tx_data is valid here
            if (start_byte) begin
                byte_d = tx_data;
                rxd_d  = tx_data[1:0];
                crc_d  = crc2(crc_q, tx_data[1:0]);
                di_d   = 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ph_q    <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            di_q    <= 2'd0;
            last_q  <= 1'b0;
            byte_q  <= 8'h00;
            crc_q   <= '1;
            rxd_q   <= 2'b00;
            crs_q   <= 1'b0;
            addr_q  <= '0;
            adv_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            ph_q    <= ~ph_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            di_q    <= di_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            crc_q   <= crc_d;
            rxd_q   <= rxd_d;
            crs_q   <= crs_d;
            addr_q  <= addr_d;
            adv_q   <= adv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

`ifdef RMII_PHY_ERR_INJ_EN
    logic        err_en_q, err_en_d;
    logic [10:0] err_byte_q, err_byte_d;
    logic        rx_err_q, rx_err_d;

    always_comb begin
        err_en_d   = err_en_q;
        err_byte_d = err_byte_q;
        rx_err_d   = rx_err_q;
        if (tx_vld && !busy_q) begin
            err_en_d   = err_inj;
            err_byte_d = err_byte;
        end
        // tx_addr_q still holds the address of the byte whose dibit goes out
        // on this step (it only advances on the 4th dibit's own edge).
        if (step) begin
            rx_err_d = (state_d == S_DATA) && err_en_q && (addr_q == err_byte_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_en_q   <= 1'b0;
            err_byte_q <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            err_en_q   <= err_en_d;
            err_byte_q <= err_byte_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign phy_rx_err = rx_err_q;
`else
    assign phy_rx_err = 1'b0;
`endif

    assign phy_clk    = ph_q;
    assign phy_rxd    = rxd_q;
    assign phy_crs_dv = crs_q;
    assign tx_addr    = addr_q;
    assign tx_adv     = adv_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_rmii_phy_rx_gen.sv
module tb_rmii_phy_rx_gen;

    localparam int PRMBL = 31;
    localparam int IFG   = 48;
    localparam logic [31:0] POLY = 32'hEDB88320;

    logic        clk;
    logic        resetn;
    logic        tx_vld;
    logic [10:0] tx_count;
    logic [10:0] tx_addr;
    logic        tx_adv;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        frame_done;
    logic        phy_clk;
    logic [1:0]  phy_rxd;
    logic        phy_crs_dv;
    logic        phy_rx_err;
`ifdef RMII_PHY_ERR_INJ_EN
    logic        err_inj;
    logic [10:0] err_byte;
`endif

    rmii_phy_rx_gen #(.PRMBL_DIBITS(PRMBL), .IFG_DIBITS(IFG)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_vld     (tx_vld),
        .tx_count   (tx_count),
        .tx_addr    (tx_addr),
        .tx_adv     (tx_adv),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .frame_done (frame_done),
`ifdef RMII_PHY_ERR_INJ_EN
        .err_inj    (err_inj),
        .err_byte   (err_byte),
`endif
        .phy_clk    (phy_clk),
        .phy_rxd    (phy_rxd),
        .phy_crs_dv (phy_crs_dv),
        .phy_rx_err (phy_rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // payload buffer with one clk of read latency
    logic [7:0] mem [0:2047];
    always @(posedge clk) tx_data <= mem[tx_addr];

    typedef struct {
        int          len;
        logic [31:0] fcs;
        int          ebyte;
    } exp_t;

    typedef struct {
        int          cnt;
        int          pat;
        bit          known;
        logic [31:0] fcs;
        int          ebyte;
    } vec_t;

    exp_t       sb_q[$];
    logic [7:0] exp_bytes[$];
    vec_t       tbl[$];

    int checks   = 0;
    int failures = 0;
    int adv_cnt  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int i);
        case (p)
            0:       return 8'h31 + 8'(i);
            1:       return 8'h00;
            2:       return 8'(i);
            default: return 8'((i * 37 + 5) ^ (i >> 8));
        endcase
    endfunction

    function automatic logic [31:0] ref_crc(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, mem[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return ~c;
    endfunction

    // ---------------- line monitor ----------------
    logic [1:0] dib_q[$];
    int         err_idx[$];
    bit         in_frame   = 0;
    bit         ifg_active = 0;
    int         ifg_cnt    = 0;

    task automatic check_frame();
        exp_t        e;
        int          bad;
        int          base;
        int          n_err;
        logic [7:0]  want;
        logic [7:0]  got;
        logic [1:0]  want_d;
        logic [31:0] fcs_got;
        if (sb_q.size() == 0) begin
            chk("unexpected_frame_dibits", dib_q.size(), 0);
        end else begin
            e = sb_q.pop_front();
            chk("crs_steps", dib_q.size(), 32 + 4 * e.len + 16);
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                want_d = (i == PRMBL) ? 2'b11 : 2'b01;
                if (i >= dib_q.size()) bad++;
                else if (dib_q[i] != want_d) bad++;
            end
            chk("preamble_sfd_bad", bad, 0);
            bad = 0;
            for (int j = 0; j < e.len; j++) begin
                want = exp_bytes.pop_front();
                base = 32 + 4 * j;
                if (base + 3 < dib_q.size())
                    got = {dib_q[base+3], dib_q[base+2], dib_q[base+1], dib_q[base]};
                else
                    got = ~want;
                if (got != want) bad++;
            end
            chk("payload_bad_bytes", bad, 0);
            fcs_got = '0;
            base = 32 + 4 * e.len;
            for (int k = 0; k < 16; k++)
                if (base + k < dib_q.size()) fcs_got[2*k +: 2] = dib_q[base+k];
            chk("fcs", fcs_got, e.fcs);
            n_err = (e.ebyte >= 0 && e.ebyte < e.len) ? 4 : 0;
            chk("rx_err_steps", err_idx.size(), n_err);
            if (n_err == 4 && err_idx.size() == 4) begin
                chk("rx_err_first", err_idx[0], 32 + 4 * e.ebyte);
                chk("rx_err_last",  err_idx[3], 32 + 4 * e.ebyte + 3);
            end
        end
        dib_q.delete();
        err_idx.delete();
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            dib_q.delete();
            err_idx.delete();
            in_frame   = 0;
            ifg_active = 0;
        end else if (phy_clk) begin
            if (phy_crs_dv) begin
                if (phy_rx_err) err_idx.push_back(dib_q.size());
                dib_q.push_back(phy_rxd);
                in_frame = 1;
            end else if (in_frame) begin
                check_frame();
                in_frame   = 0;
                ifg_active = 1;
                ifg_cnt    = 1;
            end else if (ifg_active) begin
                ifg_cnt++;
            end
            if (frame_done) begin
                chk("ifg_steps_to_done", ifg_cnt, IFG);
                chk("busy_fall_with_done", tx_busy, 0);
                ifg_active = 0;
            end
        end
    end

    always @(negedge clk) if (resetn && tx_adv) adv_cnt++;

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input int cnt, input int p, input bit known,
                               input logic [31:0] fcs, input int ebyte, input bit push);
        exp_t e;
        for (int i = 0; i <= cnt; i++) mem[i] = pat(p, i);
        if (push) begin
            e.len   = cnt + 1;
            e.fcs   = known ? fcs : ref_crc(cnt + 1);
            e.ebyte = ebyte;
            sb_q.push_back(e);
            for (int i = 0; i <= cnt; i++) exp_bytes.push_back(mem[i]);
        end
        adv_cnt = 0;
        @(posedge clk); #1;
        tx_vld   = 1'b1;
        tx_count = 11'(cnt);
`ifdef RMII_PHY_ERR_INJ_EN
        err_inj  = (ebyte >= 0);
        err_byte = (ebyte >= 0) ? 11'(ebyte) : 11'd0;
`endif
        @(posedge clk); #1;
        tx_vld = 1'b0;
        chk("busy_rise", tx_busy, 1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        chk("frame_done_seen", seen, 1);
    endtask

    task automatic wait_crs(input logic val, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (phy_crs_dv == val) seen = 1;
        end
        chk("crs_level_reached", seen, 1);
    endtask

    task automatic pulse_vld(input int cnt);
        @(posedge clk); #1;
        tx_vld   = 1'b1;
        tx_count = 11'(cnt);
        @(posedge clk); #1;
        tx_vld   = 1'b0;
    endtask

    function automatic int budget_for(input int cnt);
        return 2 * (32 + 4 * (cnt + 1) + 16 + IFG) + 200;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn   = 1'b0;
        tx_vld   = 1'b0;
        tx_count = '0;
`ifdef RMII_PHY_ERR_INJ_EN
        err_inj  = 1'b0;
        err_byte = '0;
`endif
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // vector table: count, pattern, fcs known, fcs, error byte
        tbl.push_back('{8,    0, 1'b1, 32'hCBF43926, -1});
        tbl.push_back('{0,    1, 1'b1, 32'hD202EF8D, -1});
        tbl.push_back('{63,   2, 1'b0, 32'h0,        -1});
        tbl.push_back('{20,   3, 1'b0, 32'h0,        -1});
        tbl.push_back('{2047, 3, 1'b0, 32'h0,        -1});
`ifdef RMII_PHY_ERR_INJ_EN
        tbl.push_back('{8,    0, 1'b1, 32'hCBF43926,  3});
        tbl.push_back('{8,    0, 1'b1, 32'hCBF43926,  8});
        tbl.push_back('{8,    2, 1'b0, 32'h0,        50});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_phy_clk",    phy_clk,    0);
        chk("rst_rxd",        phy_rxd,    0);
        chk("rst_crs_dv",     phy_crs_dv, 0);
        chk("rst_rx_err",     phy_rx_err, 0);
        chk("rst_tx_addr",    tx_addr,    0);
        chk("rst_tx_adv",     tx_adv,     0);
        chk("rst_tx_busy",    tx_busy,    0);
        chk("rst_frame_done", frame_done, 0);
        resetn = 1'b1;
        repeat (4) @(posedge clk);

        for (int v = 0; v < tbl.size(); v++) begin
            start_frame(tbl[v].cnt, tbl[v].pat, tbl[v].known, tbl[v].fcs, tbl[v].ebyte, 1'b1);
            wait_done(budget_for(tbl[v].cnt));
            chk("tx_adv_pulses", adv_cnt, tbl[v].cnt + 1);
            repeat (5) @(posedge clk);
        end

        // start requests during PRMBL and IFG must be ignored
        start_frame(8, 0, 1'b1, 32'hCBF43926, -1, 1'b1);
        repeat (20) @(posedge clk);
        pulse_vld(3);
        wait_crs(1'b0, budget_for(8));
        repeat (10) @(posedge clk);
        pulse_vld(3);
        wait_done(budget_for(8));
        chk("tx_adv_pulses_ignored_vld", adv_cnt, 9);
        repeat (200) @(posedge clk);
        #1;
        chk("busy_after_ignored_vld", tx_busy, 0);
        start_frame(5, 3, 1'b0, 32'h0, -1, 1'b1);
        wait_done(budget_for(5));
        chk("tx_adv_pulses_second", adv_cnt, 6);
        repeat (5) @(posedge clk);

        // reset in the middle of DATA aborts at once
        start_frame(63, 2, 1'b0, 32'h0, -1, 1'b0);
        for (int i = 0; i < 2000 && adv_cnt < 3; i++) @(negedge clk);
        chk("reached_data_before_reset", adv_cnt >= 3, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort_crs_dv",  phy_crs_dv, 0);
        chk("abort_tx_busy", tx_busy,    0);
        chk("abort_tx_addr", tx_addr,    0);
        chk("abort_rxd",     phy_rxd,    0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        start_frame(8, 0, 1'b1, 32'hCBF43926, -1, 1'b1);
        wait_done(budget_for(8));
        repeat (10) @(posedge clk);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
